// File: rtl/tulip_dsp_pkg.sv
// Shared types for the DSP-chain coefficient programming blocks.
// Holds the tap sequencer state encoding and its fixed start-to-valid latency.
package tulip_dsp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE,
    S_ERROR
  } tap_prog_state_t;

  localparam int C_TAP_PROG_LAT = 2;

endpackage

// File: rtl/tap_prog_skid_buf.sv
// Two-entry valid/ready skid stage between the tap RAM read port and the consumer.
// in_ready is registered so the RAM read issue logic never sees a combinational path from out_ready.
module tap_prog_skid_buf #(
  parameter int G_DWIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [G_DWIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [G_DWIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [G_DWIDTH-1:0] skid_q;
  logic                skid_v;

  assign in_ready = !skid_v;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      skid_q    <= '0;
      skid_v    <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_v) begin
        out_data  <= skid_q;
        out_valid <= 1'b1;
        skid_v    <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_v) begin
      skid_q <= in_data;
      skid_v <= 1'b1;
    end
  end

endmodule

// File: rtl/tap_prog_sequencer.sv
// Streams a software-filled tap RAM to a coefficient programming port.
// Optional WAIT_DONE watchdog is enabled by defining TAP_PROG_TIMEOUT_EN.
module tap_prog_sequencer
  import tulip_dsp_pkg::*;
#(
  parameter int G_DWIDTH       = 16,
  parameter int G_MAX_TAPS     = 129,
  parameter int G_DONE_TIMEOUT = 4096,
  localparam int C_AWIDTH = $clog2(G_MAX_TAPS),
  localparam int C_CWIDTH = $clog2(G_MAX_TAPS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [C_AWIDTH-1:0] wr_addr,
  input  logic [G_DWIDTH-1:0] wr_data,
  input  logic                wr_en,
  output logic                wr_ready,
  input  logic [C_CWIDTH-1:0] num_taps,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [C_CWIDTH-1:0] sent_count,
  output logic [G_DWIDTH-1:0] tap_dout,
  output logic                tap_dout_valid,
  input  logic                tap_dout_ready,
  input  logic                tap_dout_done
);

  localparam logic [C_CWIDTH-1:0] C_MAX   = C_CWIDTH'(G_MAX_TAPS);
  localparam logic [C_AWIDTH:0]   C_DEPTH = (C_AWIDTH + 1)'(G_MAX_TAPS);

  tap_prog_state_t state;

  logic [G_DWIDTH-1:0] ram [G_MAX_TAPS];
  logic [G_DWIDTH-1:0] rd_q;
  logic                rd_v;
  logic [C_CWIDTH-1:0] rd_ptr;
  logic [C_CWIDTH-1:0] num_q;
  logic [C_AWIDTH-1:0] rd_addr;

  logic in_ready;
  logic streaming;
  logic start_ok;
  logic bad_num;
  logic fire;
  logic last_fire;
  logic kill;
  logic flush;
  logic adv;
  logic issue;
  logic rd_en;
  logic wr_ok;

`ifdef TAP_PROG_TIMEOUT_EN
  localparam int C_TWIDTH = $clog2(G_DONE_TIMEOUT + 1);
  localparam logic [C_TWIDTH-1:0] C_TO_LAST = C_TWIDTH'(G_DONE_TIMEOUT - 1);
  logic [C_TWIDTH-1:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = |G_DONE_TIMEOUT;
`endif

  assign wr_ready  = state inside {S_IDLE, S_DONE, S_ERROR};
  assign busy      = state inside {S_FETCH, S_STREAM, S_WAIT_DONE};
  assign streaming = state inside {S_FETCH, S_STREAM};
  assign start_ok  = start && wr_ready;
  assign bad_num   = (num_taps == '0) || (num_taps > C_MAX);
  assign fire      = tap_dout_valid && tap_dout_ready;
  assign last_fire = fire && (sent_count == num_q - 1'b1);
  // Consumer claiming done before the final word is a protocol error.
  assign kill      = (state == S_STREAM) && tap_dout_done && !last_fire;
  assign flush     = !enable || kill;
  assign adv       = !rd_v || in_ready;
  assign issue     = streaming && adv && (rd_ptr < num_q);
  assign rd_en     = (start_ok && !bad_num) || issue;
  assign rd_addr   = streaming ? rd_ptr[C_AWIDTH-1:0] : '0;
  assign wr_ok     = wr_ready && wr_en && ({1'b0, wr_addr} < C_DEPTH);

  always_ff @(posedge clk) begin
    if (wr_ok) ram[wr_addr] <= wr_data;
    if (rd_en) rd_q <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state      <= S_IDLE;
      rd_v       <= 1'b0;
      rd_ptr     <= '0;
      num_q      <= '0;
      sent_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef TAP_PROG_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done       <= 1'b0;
            err        <= 1'b0;
            sent_count <= '0;
            num_q      <= num_taps;
            if (bad_num) begin
              state <= S_ERROR;
              err   <= 1'b1;
            end else begin
              state  <= S_FETCH;
              rd_v   <= 1'b1;
              rd_ptr <= C_CWIDTH'(1);
            end
          end
        end
        S_FETCH, S_STREAM: begin
          if (kill) begin
            state <= S_ERROR;
            err   <= 1'b1;
            rd_v  <= 1'b0;
          end else begin
            if (state == S_FETCH) state <= S_STREAM;
            if (adv) rd_v <= issue;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            if (fire && sent_count < num_q)
              sent_count <= sent_count + 1'b1;
            if (last_fire) begin
              if (tap_dout_done) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_WAIT_DONE;
              end
`ifdef TAP_PROG_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end
        end
        S_WAIT_DONE: begin
          if (tap_dout_done) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
`ifdef TAP_PROG_TIMEOUT_EN
          else if (to_cnt == C_TO_LAST) begin
            state <= S_ERROR;
            err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  tap_prog_skid_buf #(
    .G_DWIDTH (G_DWIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (rd_q),
    .in_valid  (rd_v),
    .in_ready  (in_ready),
    .out_data  (tap_dout),
    .out_valid (tap_dout_valid),
    .out_ready (tap_dout_ready)
  );

endmodule

// File: tb/tb_tap_prog_sequencer.sv
// Directed bench for tap_prog_sequencer: vector table of runs plus reset,
// enable and WAIT_DONE corner sequences.
module tb_tap_prog_sequencer;
  import tulip_dsp_pkg::*;

  localparam int DW = 16;
  localparam int MT = 129;
  localparam int AW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_ready;
  logic [CW-1:0] num_taps;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] sent_count;
  logic [DW-1:0] tap_dout;
  logic          tap_dout_valid;
  logic          tap_dout_ready;
  logic          tap_dout_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tap_prog_sequencer #(
    .G_DWIDTH       (DW),
    .G_MAX_TAPS     (MT),
    .G_DONE_TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_ready       (wr_ready),
    .num_taps       (num_taps),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .sent_count     (sent_count),
    .tap_dout       (tap_dout),
    .tap_dout_valid (tap_dout_valid),
    .tap_dout_ready (tap_dout_ready),
    .tap_dout_done  (tap_dout_done)
  );

  typedef struct {
    int       num;
    logic [3:0] pat;
    int       done_at;
    bit       same;
    bit       exp_done;
    bit       exp_err;
    int       exp_sent;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(tap_dout_valid), 0);
    chk({tag, " dout"}, 32'(tap_dout), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " sent"}, 32'(sent_count), 0);
    chk({tag, " wr_ready"}, 32'(wr_ready), 1);
  endtask

  task automatic run_case(input string tag, input vec_t v);
    int fires = 0;
    int first = -1;
    int cyc = 0;
    bit dn = 0;
    bit stall = 0;
    bit ended = 0;
    int exp_first;
    num_taps = CW'(v.num);
    tap_dout_done = 1'b0;
    tap_dout_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!ended && cyc < 600) begin
      if (done || err) begin
        ended = 1;
      end else begin
        if (stall) chk({tag, " held"}, 32'(tap_dout_valid), 1);
        if (tap_dout_valid && first < 0) first = cyc;
        if (tap_dout_valid)
          chk({tag, " word"}, 32'(tap_dout), 32'(fires + 1));
        tap_dout_ready = dn ? 1'b0 : v.pat[cyc % 4];
        stall = tap_dout_valid && !tap_dout_ready;
        if (tap_dout_valid && tap_dout_ready) begin
          fires++;
          if (v.same && fires == v.done_at) tap_dout_done = 1'b1;
        end
        tick();
        cyc++;
        if (!v.same && fires >= v.done_at) begin
          dn = 1;
          tap_dout_done = 1'b1;
        end
      end
    end
    exp_first = (v.exp_sent > 0) ? C_TAP_PROG_LAT : -1;
    chk({tag, " finished"}, 32'(ended), 1);
    chk({tag, " first valid"}, 32'(first), 32'(exp_first));
    chk({tag, " fires"}, 32'(fires), 32'(v.exp_sent));
    chk({tag, " done"}, 32'(done), 32'(v.exp_done));
    chk({tag, " err"}, 32'(err), 32'(v.exp_err));
    chk({tag, " sent"}, 32'(sent_count), 32'(v.exp_sent));
    chk({tag, " valid after"}, 32'(tap_dout_valid), 0);
    chk({tag, " busy after"}, 32'(busy), 0);
    chk({tag, " wr_ready"}, 32'(wr_ready), 1);
    tap_dout_done = 1'b0;
    tap_dout_ready = 1'b0;
    tick();
  endtask

  vec_t vecs [7];

  initial begin
    int fires;
    int cnt;
    vecs[0] = '{129, 4'b1111, 129, 0, 1, 0, 129};
    vecs[1] = '{4,   4'b1001, 4,   0, 1, 0, 4};
    vecs[2] = '{0,   4'b1111, 1000, 0, 0, 1, 0};
    vecs[3] = '{130, 4'b1111, 1000, 0, 0, 1, 0};
    vecs[4] = '{10,  4'b1111, 6,   0, 0, 1, 6};
    vecs[5] = '{3,   4'b1111, 3,   1, 1, 0, 3};
    vecs[6] = '{7,   4'b0110, 7,   0, 1, 0, 7};

    reset = 1'b1;
    enable = 1'b1;
    wr_addr = '0;
    wr_data = '0;
    wr_en = 1'b0;
    num_taps = '0;
    start = 1'b0;
    tap_dout_ready = 1'b0;
    tap_dout_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_idle("reset");

    for (int a = 0; a < MT; a++) begin
      wr_addr = AW'(a);
      wr_data = DW'(a + 1);
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run_case($sformatf("vec%0d", i), vecs[i]);

    // reset landing on the 3rd fire of a 10-word run
    num_taps = CW'(10);
    tap_dout_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fires = 0;
    for (int c = 0; c < 20 && fires < 3; c++) begin
      if (tap_dout_valid) begin
        fires++;
        if (fires == 3) reset = 1'b1;
      end
      tick();
    end
    reset = 1'b0;
    tap_dout_ready = 1'b0;
    chk("midrun fires", 32'(fires), 3);
    chk_idle("midrun reset");
    tick();
    run_case("replay", '{10, 4'b1111, 10, 0, 1, 0, 10});

    // enable drop mid-run
    num_taps = CW'(10);
    tap_dout_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("en busy", 32'(busy), 1);
    enable = 1'b0;
    tick();
    chk_idle("enable low");
    enable = 1'b1;
    tap_dout_ready = 1'b0;
    tick();

    // consumer never reports done
    num_taps = CW'(2);
    tap_dout_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fires = 0;
    for (int c = 0; c < 20; c++) begin
      if (tap_dout_valid && tap_dout_ready) fires++;
      tick();
      if (fires == 2) break;
    end
    chk("wait fires", 32'(fires), 2);
    chk("wait busy", 32'(busy), 1);
    chk("wait wr_ready", 32'(wr_ready), 0);
    wr_addr = '0;
    wr_data = 16'hDEAD;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    cnt = 1;
`ifdef TAP_PROG_TIMEOUT_EN
    while (!err && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("timeout cycles", 32'(cnt), 16);
    chk("timeout err", 32'(err), 1);
    chk("timeout busy", 32'(busy), 0);
`else
    repeat (100) tick();
    chk("no timeout busy", 32'(busy), 1);
    chk("no timeout err", 32'(err), 0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
`endif
    tap_dout_ready = 1'b0;
    tick();
    run_case("post write", '{1, 4'b1111, 1, 0, 1, 0, 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
